cost_acc: RTL

COST_ACC -- requirements
Module: cost_acc

---
 rtl/cost_acc_pkg.sv | 19 +
 rtl/sat_sq.sv | 44 ++++
 rtl/cost_acc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cost_acc_pkg.sv
// Shared constants for the cost accumulator: FSM state encoding, default
// fixed-point format and a small sizing helper.
package cost_acc_pkg;

  // Default number of fractional bits; 1.0 = 2**16.
  localparam int DEFAULT_FRAC = 16;

  // Sample-processing FSM: wait for a sample, then walk its outputs.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  // Width of a counter able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_sq.sv
// Saturating error term: d = sat(y - t), sq = sat((d * d) >>> FRAC).
// Purely combinational; the top reuses one instance for every output index.
module sat_sq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] t_i,
  output logic signed [WIDTH-1:0] d_o,
  output logic signed [WIDTH-1:0] sq_o
);

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH:0]     diff;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_shr;

  // One extra bit makes the subtraction exact before clamping.
  assign diff = {y_i[WIDTH-1], y_i} - {t_i[WIDTH-1], t_i};

  // Clamp the difference when the two top bits disagree (overflow).
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
    d_o = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      d_o = diff[WIDTH] ? S_MIN : S_MAX;
    end
  end

  // The product is never negative, so anything above the top WIDTH-1 bits overflows.
  assign prod     = d_o * d_o;
  assign prod_shr = prod >>> FRAC;

  // Saturate the scaled square to the largest positive word.
  always_comb begin
    sq_o = prod_shr[WIDTH-1:0];
    if (|prod_shr[2*WIDTH-1:WIDTH-1]) begin
      sq_o = S_MAX;
    end
  end

endmodule

// File: rtl/cost_acc.sv
// Batch cost accumulator: for each accepted sample, emits the per-output
// error vector y-t and accumulates the sum of squared errors over BATCH
// samples, reporting the saturated batch cost.
module cost_acc
  import cost_acc_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int WIDTH = 32,
  parameter int FRAC  = DEFAULT_FRAC,
  parameter int BATCH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [N_OUT*WIDTH-1:0]   i_y,
  input  logic signed [N_OUT*WIDTH-1:0]   i_t,
  input  logic                            i_valid,
  input  logic                            i_clr,
  output logic                            o_ready,
  output logic signed [N_OUT*WIDTH-1:0]   o_delta,
  output logic                            o_delta_valid,
  output logic signed [WIDTH-1:0]         o_cost,
  output logic                            o_cost_valid
);

  localparam int IDX_W = idx_width(N_OUT);
  localparam int CNT_W = $clog2(BATCH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(BATCH);
  localparam logic [WIDTH-1:0] ACC_MAX   = {1'b0, {(WIDTH-1){1'b1}}};

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [WIDTH-1:0]        acc_q;
  logic [WIDTH-1:0]        acc_d;
  logic [N_OUT*WIDTH-1:0]  y_q;
  logic [N_OUT*WIDTH-1:0]  t_q;
  logic [N_OUT*WIDTH-1:0]  delta_q;
  logic [WIDTH-1:0]        cost_q;
  logic                    delta_valid_q;
  logic                    cost_valid_q;

  logic signed [WIDTH-1:0] cur_y;
  logic signed [WIDTH-1:0] cur_t;
  logic signed [WIDTH-1:0] cur_d;
  logic signed [WIDTH-1:0] cur_sq;
  logic [WIDTH:0]          acc_sum;

  assign cur_y = y_q[idx_q*WIDTH +: WIDTH];
  assign cur_t = t_q[idx_q*WIDTH +: WIDTH];

  sat_sq #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_sat_sq (
    .y_i  (cur_y),
    .t_i  (cur_t),
    .d_o  (cur_d),
    .sq_o (cur_sq)
  );

  // Both addends are non-negative, so a carry into either top bit means overflow.
  assign acc_sum = {1'b0, acc_q} + {1'b0, cur_sq};
  assign acc_d   = (acc_sum[WIDTH] || acc_sum[WIDTH-1]) ? ACC_MAX : acc_sum[WIDTH-1:0];
  assign cnt_d   = cnt_q + 1'b1;

  assign o_ready       = (state_q == ST_IDLE);
  assign o_delta       = delta_q;
  assign o_delta_valid = delta_valid_q;
  assign o_cost        = cost_q;
  assign o_cost_valid  = cost_valid_q;

  // Sample FSM: latch a sample, process one output per cycle, report on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      delta_q       <= '0;
      cost_q        <= '0;
      delta_valid_q <= 1'b0;
      cost_valid_q  <= 1'b0;
    end else if (i_clr) begin
      // Abort wins over everything; the last reported delta and cost stay visible.
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      delta_valid_q <= 1'b0;
      cost_valid_q  <= 1'b0;
    end else begin
      delta_valid_q <= 1'b0;
      cost_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            // NOTE: y_q/t_q are plain data holding registers, loaded before use, so they carry no reset.
            y_q     <= i_y;
            t_q     <= i_t;
            idx_q   <= '0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          delta_q[idx_q*WIDTH +: WIDTH] <= cur_d;
          if (idx_q == LAST_IDX) begin
            state_q       <= ST_IDLE;
            delta_valid_q <= 1'b1;
            if (cnt_d == BATCH_CNT) begin
              cost_q       <= acc_d;
              cost_valid_q <= 1'b1;
              acc_q        <= '0;
              cnt_q        <= '0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
            acc_q <= acc_d;
          end
        end
      endcase
    end
  end

endmodule
